truth_table_capture: RTL and testbench

Sequential truth-table reader for 4-input combinational functions in the lab designs. It drives `abcd` = 0..15 into a function under test and samples its 1-bit output `f_in` for each vector. It builds the 16-bit truth table and minterm count, then streams the minterm indices out over a valid/ready handshake. This is the hardware replacement for the manual sweep-and-print benches: it recovers the function from its output instead of computing the output from the function.

---
 rtl/truth_table_capture.sv | 139 +++++++++++++
 tb/tb_truth_table_capture.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_capture.sv
// Sweeps abcd = 0..15 through a 4-input function, captures its truth table and minterm count,
// and optionally streams the minterm indices (build macro TT_CAPTURE_STREAM_EN).
module truth_table_capture #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [3:0]  abcd,
  input  logic        f_in,
  output logic        busy,
  output logic [15:0] tt,
  output logic [4:0]  ones_cnt,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [3:0]  m_index,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, SWEEP, EMIT, FIN} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] tt_smp;
  logic        sample;

  assign sample = (cnt == CNT_LAST);

  always_comb begin
    tt_smp       = tt;
    tt_smp[abcd] = f_in;
  end

`ifdef TT_CAPTURE_STREAM_EN
  logic [15:0] pending;
  logic [15:0] pending_clr;

  function automatic logic [3:0] lowest(input logic [15:0] v);
    logic found;
    lowest = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (v[i] && !found) begin
        lowest = 4'(i);
        found  = 1'b1;
      end
    end
  endfunction

  always_comb begin
    pending_clr = pending;
    if (m_valid && m_ready)
      pending_clr[m_index] = 1'b0;
  end
`else
  logic unused_ready;
  assign unused_ready = m_ready;
  assign m_valid      = 1'b0;
  assign m_index      = '0;
`endif

  // m_valid/m_index are registered from the next value of pending so they
  // always equal (pending != 0) and lowest(pending) in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      abcd     <= '0;
      busy     <= 1'b0;
      tt       <= '0;
      ones_cnt <= '0;
      done     <= 1'b0;
      cnt      <= '0;
`ifdef TT_CAPTURE_STREAM_EN
      pending  <= '0;
      m_valid  <= 1'b0;
      m_index  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SWEEP;
            busy     <= 1'b1;
            abcd     <= '0;
            tt       <= '0;
            ones_cnt <= '0;
            cnt      <= '0;
          end
        end
        SWEEP: begin
          if (sample) begin
            tt       <= tt_smp;
            ones_cnt <= ones_cnt + {4'b0000, f_in};
            cnt      <= '0;
            if (abcd == 4'hF) begin
`ifdef TT_CAPTURE_STREAM_EN
              state   <= EMIT;
              pending <= tt_smp;
              m_valid <= |tt_smp;
              m_index <= lowest(tt_smp);
`else
              state <= FIN;
              done  <= 1'b1;
`endif
            end else begin
              abcd <= abcd + 4'd1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
`ifdef TT_CAPTURE_STREAM_EN
        EMIT: begin
          if (pending == '0) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            pending <= pending_clr;
            m_valid <= |pending_clr;
            m_index <= lowest(pending_clr);
          end
        end
`endif
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_capture.sv
// Bench for truth_table_capture: table-driven captures with a minterm scoreboard,
// plus hand-written SETTLE=3, stall and mid-capture reset sequences.
module tb_truth_table_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic        start0 = 1'b0, f0, busy0, mv0, mr0 = 1'b1, done0;
  logic [3:0]  abcd0, mi0;
  logic [15:0] tt0;
  logic [4:0]  ones0;

  logic        start3 = 1'b0, f3, busy3, mv3, mr3 = 1'b1, done3;
  logic [3:0]  abcd3, mi3;
  logic [15:0] tt3;
  logic [4:0]  ones3;

  truth_table_capture u0 (
    .clk(clk), .rst(rst), .start(start0), .abcd(abcd0), .f_in(f0), .busy(busy0),
    .tt(tt0), .ones_cnt(ones0), .m_valid(mv0), .m_ready(mr0), .m_index(mi0), .done(done0)
  );

  truth_table_capture #(.SETTLE(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .abcd(abcd3), .f_in(f3), .busy(busy3),
    .tt(tt3), .ones_cnt(ones3), .m_valid(mv3), .m_ready(mr3), .m_index(mi3), .done(done3)
  );

  // Function under test for u0: the lab function or an arbitrary table.
  logic        fsel = 1'b0;
  logic [15:0] pat  = '0;

  function automatic logic spec_fn(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return (~c & d) | (a & ~c) | (a & ~b) | (~a & b & d);
  endfunction

  always_comb f0 = fsel ? pat[abcd0] : spec_fn(abcd0);

  // u3 sees abcd[0] delayed by two cycles.
  logic d1 = 1'b0, d2 = 1'b0;
  always @(posedge clk) begin
    d1 <= abcd3[0];
    d2 <= d1;
  end
  assign f3 = d2;

`ifdef TT_CAPTURE_STREAM_EN
  localparam bit STREAM = 1'b1;
`else
  localparam bit STREAM = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        fsel;
    logic [15:0] pat;
    logic        tog;
    logic [15:0] exp_tt;
    logic [4:0]  exp_ones;
  } vec_t;

  vec_t vecs[6];
  int   sb[$];

  function automatic int exp_done(input int n, input logic tog);
    if (!STREAM) return 16;
    if (n == 0)  return 17;
    return tog ? 16 + 2 * n : 17 + n;
  endfunction

  task automatic run_vec(input vec_t v);
    int e, done_e, busy_fall, pulses, abcd_bad, exp;
    logic mv_seen, stalled;
    logic [3:0] stall_idx;
    fsel = v.fsel;
    pat  = v.pat;
    sb.delete();
    if (STREAM)
      for (int unsigned k = 0; k < 16; k++)
        if (v.exp_tt[k]) sb.push_back(int'(k));
    mr0 = 1'b1;
    @(negedge clk) start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    e = 0; done_e = -1; busy_fall = -1; pulses = 0; abcd_bad = 0;
    mv_seen = 1'b0; stalled = 1'b0; stall_idx = '0;
    while (e < 200 && busy_fall < 0) begin
      @(posedge clk);
      #1;
      e++;
      mr0 = !v.tog || (e % 2 == 0);
      if (e <= 15 && abcd0 !== 4'(e)) abcd_bad++;
      if (e >= 16 && abcd0 !== 4'hF) abcd_bad++;
      if (stalled) begin
        check("stall_hold", {27'd0, mv0, mi0}, {27'd0, 1'b1, stall_idx});
        stalled = 1'b0;
      end
      if (mv0) mv_seen = 1'b1;
      if (mv0 && mr0) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_index: got %0d expected none", mi0);
        end else begin
          exp = sb.pop_front();
          check("m_index", 32'(mi0), 32'(exp));
        end
      end else if (mv0) begin
        stalled   = 1'b1;
        stall_idx = mi0;
      end
      if (done0) begin
        pulses++;
        if (done_e < 0) done_e = e;
      end
      if (done_e >= 0 && !busy0) busy_fall = e;
    end
    check("tt", 32'(tt0), 32'(v.exp_tt));
    check("ones_cnt", 32'(ones0), 32'(v.exp_ones));
    check("done_edge", 32'(done_e), 32'(exp_done(int'(v.exp_ones), v.tog)));
    check("done_pulses", 32'(pulses), 32'd1);
    check("busy_fall", 32'(busy_fall), 32'(done_e + 1));
    check("abcd_seq_errors", 32'(abcd_bad), 32'd0);
    check("indices_left", 32'(sb.size()), 32'd0);
    check("m_valid_seen", 32'(mv_seen), 32'(STREAM && v.exp_ones != 0));
  endtask

  initial begin
    int e, hs, done_e, pulses, abcd_bad;
    logic [15:0] rnd;

    rnd = 16'($urandom);
    vecs[0] = '{1'b0, 16'h0000, 1'b0, 16'h3FA2, 5'd9};
    vecs[1] = '{1'b1, 16'h0000, 1'b0, 16'h0000, 5'd0};
    vecs[2] = '{1'b1, 16'hFFFF, 1'b0, 16'hFFFF, 5'd16};
    vecs[3] = '{1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 5'd16};
    vecs[4] = '{1'b1, 16'h8001, 1'b1, 16'h8001, 5'd2};
    vecs[5] = '{1'b1, rnd, 1'b0, rnd, 5'($countones(rnd))};

    // Reset with start held high: nothing may begin.
    rst = 1'b1; start0 = 1'b1; start3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {abcd0, busy0, tt0, ones0, mv0, mi0, done0},
          32'd0);
    check("rst_busy3", 32'(busy3), 32'd0);
    @(negedge clk) begin rst = 1'b0; start0 = 1'b0; start3 = 1'b0; end
    @(posedge clk);
    #1 check("idle_after_rst", 32'(busy0), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // SETTLE=3 with a delayed function and a stray mid-sweep start.
    mr3 = 1'b1;
    @(negedge clk) start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    e = 0; hs = 0; done_e = -1; abcd_bad = 0;
    while (e < 300 && !(done_e >= 0 && !busy3)) begin
      @(posedge clk);
      #1;
      e++;
      start3 = (e == 20);
      if (e < 48 && e % 3 == 0 && abcd3 !== 4'(e / 3)) abcd_bad++;
      if (mv3 && mr3) begin
        check("s3_index", 32'(mi3), 32'(2 * hs + 1));
        hs++;
      end
      if (done3 && done_e < 0) done_e = e;
    end
    start3 = 1'b0;
    check("s3_tt", 32'(tt3), 32'hAAAA);
    check("s3_ones", 32'(ones3), 32'd8);
    check("s3_done_edge", 32'(done_e), STREAM ? 32'd57 : 32'd48);
    check("s3_handshakes", 32'(hs), STREAM ? 32'd8 : 32'd0);
    check("s3_abcd_errors", 32'(abcd_bad), 32'd0);
    repeat (3) @(posedge clk);
    #1 check("s3_no_restart", 32'(busy3), 32'd0);

    // Reset in the middle of a capture (after 3 handshakes when streaming).
    fsel = 1'b0;
    mr0  = 1'b1;
    @(negedge clk) start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    e = 0; hs = 0;
    while (e < 100) begin
      @(posedge clk);
      #1;
      e++;
      if (mv0 && mr0) hs++;
      if (STREAM ? (hs == 3) : (e == 10)) break;
    end
    check("pre_rst_busy", 32'(busy0), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_outputs", {abcd0, busy0, tt0, ones0, mv0, mi0, done0}, 32'd0);
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (done0) pulses++;
    end
    check("mid_rst_no_done", 32'(pulses), 32'd0);
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
